hpu_cmd_slot_tracker: RTL and testbench

//  Per-cluster tracker of in-flight HPU commands; generalises fixed NUM_CORES x NUM_HPU_CMDS local IDs.

---
 rtl/hpu_cmd_slot_tracker.sv | 163 ++++++++++++++++
 tb/tb_hpu_cmd_slot_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hpu_cmd_slot_tracker.sv
// Per-cluster in-flight HPU command tracker: NUM_SLOTS slots per core, lowest-free allocation, free on response.
// Optional sticky protocol error flag is built only when HPU_CMD_TRACK_ERR_EN is defined.
module hpu_cmd_slot_tracker #(
    parameter  int NUM_CORES    = 8,
    parameter  int NUM_SLOTS    = 4,
    parameter  int CLUSTER_ID_W = 2,
    localparam int CORE_ID_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int SLOT_W       = $clog2(NUM_SLOTS)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [CLUSTER_ID_W-1:0]           cluster_id_i,
    input  logic [NUM_CORES-1:0]              alloc_valid_i,
    output logic [NUM_CORES-1:0]              alloc_ready_o,
    output logic [NUM_CORES*SLOT_W-1:0]       alloc_id_o,
    input  logic                              resp_valid_i,
    input  logic [CLUSTER_ID_W-1:0]           resp_cluster_i,
    input  logic [CORE_ID_W-1:0]              resp_core_i,
    input  logic [SLOT_W-1:0]                 resp_slot_i,
    output logic [NUM_CORES*NUM_SLOTS-1:0]    busy_o,
    output logic [NUM_CORES*(SLOT_W+1)-1:0]   outstanding_o,
    output logic                              done_valid_o,
    output logic [CORE_ID_W-1:0]              done_core_o,
    output logic [SLOT_W-1:0]                 done_slot_o,
    output logic                              idle_o,
    output logic                              err_o
);

    localparam int NB    = NUM_CORES * NUM_SLOTS;
    localparam int CNT_W = SLOT_W + 1;

    // Lowest-index zero bit; scanning downward lets the lowest free slot win.
    function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] b);
        logic [SLOT_W-1:0] id;
        id = {SLOT_W{1'b0}};
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            id = b[i] ? id : i[SLOT_W-1:0];
        end
        return id;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_SLOTS-1:0] b);
        logic [CNT_W-1:0] n;
        n = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + {{SLOT_W{1'b0}}, b[i]};
        end
        return n;
    endfunction

    logic [NB-1:0]              r_busy;
    logic [NUM_CORES*CNT_W-1:0] r_outstanding;
    logic                       r_idle;
    logic                       r_done_valid;
    logic [CORE_ID_W-1:0]       r_done_core;
    logic [SLOT_W-1:0]          r_done_slot;

    logic [NUM_CORES-1:0]        w_ready;
    logic [NUM_CORES*SLOT_W-1:0] w_alloc_id;
    logic [NUM_CORES-1:0]        w_fire;
    logic [NB-1:0]               w_set_vec;
    logic [NB-1:0]               w_sel;
    logic [NB-1:0]               w_free_vec;
    logic                        w_resp_own;
    logic                        w_free_hit;
    logic [NB-1:0]               w_busy_nxt;
    logic [NUM_CORES*CNT_W-1:0]  w_out_nxt;

    // Allocation view works on the pre-free busy set so a slot freed this cycle is not reissued yet.
    always_comb begin
        w_ready    = {NUM_CORES{1'b0}};
        w_alloc_id = {(NUM_CORES*SLOT_W){1'b0}};
        w_fire     = {NUM_CORES{1'b0}};
        w_set_vec  = {NB{1'b0}};
        for (int c = 0; c < NUM_CORES; c++) begin
            w_ready[c] = ~&r_busy[c*NUM_SLOTS +: NUM_SLOTS];
            w_alloc_id[c*SLOT_W +: SLOT_W] = lowest_free(r_busy[c*NUM_SLOTS +: NUM_SLOTS]);
            w_fire[c] = alloc_valid_i[c] & w_ready[c];
            for (int s = 0; s < NUM_SLOTS; s++) begin
                w_set_vec[c*NUM_SLOTS+s] = w_fire[c] &
                    (w_alloc_id[c*SLOT_W +: SLOT_W] == s[SLOT_W-1:0]);
            end
        end
    end

    // Response decode: one-hot slot select; out-of-range cores never match any slot.
    always_comb begin
        w_sel      = {NB{1'b0}};
        w_resp_own = resp_valid_i & (resp_cluster_i == cluster_id_i);
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                w_sel[c*NUM_SLOTS+s] = (resp_core_i == c[CORE_ID_W-1:0]) &
                                       (resp_slot_i == s[SLOT_W-1:0]);
            end
        end
        w_free_vec = w_sel & r_busy & {NB{w_resp_own}};
        w_free_hit = |w_free_vec;
    end

    // Next busy set and per-core counts; set and clear bits are disjoint by construction.
    always_comb begin
        w_busy_nxt = (r_busy | w_set_vec) & ~w_free_vec;
        w_out_nxt  = {(NUM_CORES*CNT_W){1'b0}};
        for (int c = 0; c < NUM_CORES; c++) begin
            w_out_nxt[c*CNT_W +: CNT_W] = popcount(w_busy_nxt[c*NUM_SLOTS +: NUM_SLOTS]);
        end
    end

    // Tracker state and completion reporting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy        <= {NB{1'b0}};
            r_outstanding <= {(NUM_CORES*CNT_W){1'b0}};
            r_idle        <= 1'b1;
            r_done_valid  <= 1'b0;
            r_done_core   <= {CORE_ID_W{1'b0}};
            r_done_slot   <= {SLOT_W{1'b0}};
        end else begin
            r_busy        <= w_busy_nxt;
            r_outstanding <= w_out_nxt;
            r_idle        <= ~|w_busy_nxt;
            r_done_valid  <= w_free_hit;
            if (w_free_hit) begin
                r_done_core <= resp_core_i;
                r_done_slot <= resp_slot_i;
            end else begin
                r_done_core <= r_done_core;
                r_done_slot <= r_done_slot;
            end
        end
    end

`ifdef HPU_CMD_TRACK_ERR_EN
    logic r_err;
    logic w_err_evt;

    // Any own-cluster response that frees nothing is either a non-busy slot or a bad core index.
    assign w_err_evt = (w_resp_own & ~w_free_hit) | (|(alloc_valid_i & ~w_ready));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_err_evt;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign alloc_ready_o = w_ready;
    assign alloc_id_o    = w_alloc_id;
    assign busy_o        = r_busy;
    assign outstanding_o = r_outstanding;
    assign idle_o        = r_idle;
    assign done_valid_o  = r_done_valid;
    assign done_core_o   = r_done_core;
    assign done_slot_o   = r_done_slot;

endmodule

// File: tb/tb_hpu_cmd_slot_tracker.sv
// Scoreboard bench for hpu_cmd_slot_tracker: a slot-array model predicts allocation, frees and done pulses.
module tb_hpu_cmd_slot_tracker;

    localparam int NC = 8;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int CW = 3;
    localparam logic [1:0] CID = 2'd2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [1:0]        cluster_id_i;
    logic [NC-1:0]     alloc_valid_i;
    logic [NC-1:0]     alloc_ready_o;
    logic [NC*SW-1:0]  alloc_id_o;
    logic              resp_valid_i;
    logic [1:0]        resp_cluster_i;
    logic [CW-1:0]     resp_core_i;
    logic [SW-1:0]     resp_slot_i;
    logic [NC*NS-1:0]  busy_o;
    logic [NC*(SW+1)-1:0] outstanding_o;
    logic              done_valid_o;
    logic [CW-1:0]     done_core_o;
    logic [SW-1:0]     done_slot_o;
    logic              idle_o;
    logic              err_o;

    int n_vec = 0;
    int n_err = 0;

    logic [NC*NS-1:0]  m_busy;
    logic              m_err;
    logic [CW+SW-1:0]  m_last;
    logic [CW+SW-1:0]  exp_q[$];

    hpu_cmd_slot_tracker #(.NUM_CORES(NC), .NUM_SLOTS(NS), .CLUSTER_ID_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cluster_id_i(cluster_id_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
        .resp_valid_i(resp_valid_i), .resp_cluster_i(resp_cluster_i), .resp_core_i(resp_core_i),
        .resp_slot_i(resp_slot_i), .busy_o(busy_o), .outstanding_o(outstanding_o),
        .done_valid_o(done_valid_o), .done_core_o(done_core_o), .done_slot_o(done_slot_o),
        .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_lowest(input int c);
        for (int s = 0; s < NS; s++) begin
            if (!m_busy[c*NS+s]) return s;
        end
        return -1;
    endfunction

    task automatic post_checks();
        logic [CW+SW-1:0] e;
        chk("busy", 64'(busy_o), 64'(m_busy));
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("outst%0d", c), 64'(outstanding_o[c*(SW+1) +: SW+1]),
                64'($countones(m_busy[c*NS +: NS])));
        end
        chk("idle", 64'(idle_o), 64'(m_busy == '0));
        if (done_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("done_spurious", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                m_last = e;
                chk("done_id", 64'({done_core_o, done_slot_o}), 64'(e));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            m_last = e;
            chk("done_missing", 64'(0), 64'(1));
        end
        chk("done_hold", 64'({done_core_o, done_slot_o}), 64'(m_last));
        chk("err", 64'(err_o), 64'(m_err));
    endtask

    // One clock cycle: drive, check combinational alloc view, advance model, check registered state.
    task automatic step(input logic [NC-1:0] av, input logic rv, input logic [1:0] rcl,
                        input logic [CW-1:0] rcore, input logic [SW-1:0] rslot);
        logic [NC*NS-1:0] nb;
        int low;
        int idx;
        alloc_valid_i = av; resp_valid_i = rv; resp_cluster_i = rcl;
        resp_core_i = rcore; resp_slot_i = rslot;
        #1;
        nb = m_busy;
        for (int c = 0; c < NC; c++) begin
            low = model_lowest(c);
            chk($sformatf("ready%0d", c), 64'(alloc_ready_o[c]), 64'(low >= 0));
            if (low >= 0) begin
                chk($sformatf("alloc_id%0d", c), 64'(alloc_id_o[c*SW +: SW]), 64'(low));
                if (av[c]) nb[c*NS+low] = 1'b1;
            end else if (av[c]) begin
`ifdef HPU_CMD_TRACK_ERR_EN
                m_err = 1'b1;
`endif
            end
        end
        if (rv && rcl == CID) begin
            idx = int'(rcore) * NS + int'(rslot);
            if (m_busy[idx]) begin
                nb[idx] = 1'b0;
                exp_q.push_back({rcore, rslot});
            end else begin
`ifdef HPU_CMD_TRACK_ERR_EN
                m_err = 1'b1;
`endif
            end
        end
        @(posedge clk_i);
        #1;
        m_busy = nb;
        alloc_valid_i = '0; resp_valid_i = 1'b0;
        post_checks();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        alloc_valid_i = '0; resp_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_busy = '0; m_err = 1'b0; m_last = '0;
        exp_q.delete();
    endtask

    initial begin
        logic [NC-1:0] av;
        int rc;
        cluster_id_i = CID;
        resp_cluster_i = 2'd0; resp_core_i = '0; resp_slot_i = '0;
        do_reset();

        // Reset state
        chk("rst_idle", 64'(idle_o), 64'(1));
        chk("rst_ready", 64'(alloc_ready_o), 64'(8'hFF));
        chk("rst_alloc_id", 64'(alloc_id_o), 64'(0));
        chk("rst_outst", 64'(outstanding_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_valid_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));

        // Core 3 fills all four slots back-to-back
        for (int k = 0; k < 4; k++) begin
            chk("t2_id", 64'(alloc_id_o[3*SW +: SW]), 64'(k));
            step(8'h08, 1'b0, CID, 3'd0, 2'd0);
        end
        chk("t2_full", 64'(alloc_ready_o[3]), 64'(0));
        chk("t2_outst", 64'(outstanding_o[3*3 +: 3]), 64'(4));
        chk("t2_others", 64'(alloc_ready_o), 64'(8'hF7));

        // Free core 3 slot 1
        step(8'h00, 1'b1, CID, 3'd3, 2'd1);
        chk("t3_bit13", 64'(busy_o[13]), 64'(0));
        chk("t3_done", 64'(done_valid_o), 64'(1));
        chk("t3_id", 64'(alloc_id_o[3*SW +: SW]), 64'(1));
        chk("t3_outst", 64'(outstanding_o[3*3 +: 3]), 64'(3));

        // Core 0: slots {0,1}, then alloc + free slot 0 together
        step(8'h01, 1'b0, CID, 3'd0, 2'd0);
        step(8'h01, 1'b0, CID, 3'd0, 2'd0);
        chk("t4_pre_id", 64'(alloc_id_o[1:0]), 64'(2));
        step(8'h01, 1'b1, CID, 3'd0, 2'd0);
        chk("t4_busy", 64'(busy_o[3:0]), 64'(4'b0110));
        chk("t4_outst", 64'(outstanding_o[2:0]), 64'(2));
        chk("t4_reuse", 64'(alloc_id_o[1:0]), 64'(0));
        step(8'h01, 1'b0, CID, 3'd0, 2'd0);

        // Foreign-cluster response is ignored
        step(8'h00, 1'b1, 2'd1, 3'd0, 2'd1);
        chk("t5_nodone", 64'(done_valid_o), 64'(0));
        chk("t5_busy", 64'(busy_o[3:0]), 64'(4'b0111));

`ifdef HPU_CMD_TRACK_ERR_EN
        // Free of an idle slot sets a sticky error
        step(8'h00, 1'b1, CID, 3'd5, 2'd2);
        chk("t6_err", 64'(err_o), 64'(1));
        step(8'h00, 1'b0, CID, 3'd0, 2'd0);
        chk("t6_sticky", 64'(err_o), 64'(1));
`endif

        // Randomised mixed traffic
        for (int i = 0; i < 300; i++) begin
            av = NC'($urandom) & NC'($urandom);
            rc = $urandom_range(0, 7);
            step(av, 1'($urandom), (rc == 0) ? 2'd1 : CID,
                 CW'($urandom), SW'($urandom));
        end

        // Mid-traffic reset
        step(8'hFF, 1'b0, CID, 3'd0, 2'd0);
        do_reset();
        chk("rst2_idle", 64'(idle_o), 64'(1));
        chk("rst2_busy", 64'(busy_o), 64'(0));
        chk("rst2_err", 64'(err_o), 64'(0));
        step(8'h00, 1'b1, CID, 3'd0, 2'd0);
        step(8'h00, 1'b0, CID, 3'd0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
